// File: rtl/keypad_symbol_tx.sv
// Button-to-symbol transmitter: synchronizes and debounces four push-buttons and
// emits one KB_IN symbol, framed by a KB_RECV strobe, for each accepted press.
module keypad_symbol_tx #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
    output logic       KB_RECV,
    output logic [1:0] KB_IN,
    output logic       BUSY
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > SETUP_CYCLES) ? DEBOUNCE_CYCLES : SETUP_CYCLES;
    localparam int MAX_P  = (MAX_AB > STROBE_CYCLES) ? MAX_AB : STROBE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SETUP,
        STROBE,
        RELEASE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       code, code_nxt;
    logic [1:0]       kb_in_nxt;
    logic             kb_recv_nxt;
    logic             busy_nxt;
    logic [3:0]       btn_meta, btn_s;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Raw buttons are asynchronous; only btn_s is used beyond this point.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_meta <= 4'd0;
            btn_s    <= 4'd0;
        end else begin
            btn_meta <= BTN;
            btn_s    <= btn_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= '0;
            code    <= 2'd0;
            KB_IN   <= 2'd0;
            KB_RECV <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            code    <= code_nxt;
            KB_IN   <= kb_in_nxt;
            KB_RECV <= kb_recv_nxt;
            BUSY    <= busy_nxt;
        end
    end

    // Every state transition clears cnt, so each state times itself from zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        code_nxt    = code;
        kb_in_nxt   = KB_IN;
        kb_recv_nxt = KB_RECV;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (is_onehot(btn_s)) begin
                    code_nxt  = encode(btn_s);
                    state_nxt = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (btn_s != (4'b0001 << code)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    kb_in_nxt = code;
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            SETUP: begin
                if (cnt == SET_LAST) begin
                    kb_recv_nxt = 1'b1;
                    state_nxt   = STROBE;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            STROBE: begin
                if (cnt == STB_LAST) begin
                    kb_recv_nxt = 1'b0;
                    state_nxt   = RELEASE;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            RELEASE: begin
                if (btn_s != 4'd0) begin
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                cnt_nxt     = '0;
                kb_recv_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_keypad_symbol_tx.sv
// Scoreboard bench for keypad_symbol_tx: expected symbols are queued per press and
// matched against KB_IN on every KB_RECV rising edge.
module tb_keypad_symbol_tx;

    localparam int DEB = 16;
    localparam int SET = 2;
    localparam int STB = 4;

    logic       CLK;
    logic       RST_N;
    logic [3:0] BTN;
    logic       KB_RECV;
    logic [1:0] KB_IN;
    logic       BUSY;

    int         checks = 0;
    int         errors = 0;
    int         n_push = 0;
    int         n_strobe = 0;
    logic [1:0] sb_q[$];

    logic       prev_recv = 1'b0;
    logic [1:0] prev_kb = 2'd0;
    logic [1:0] cur_exp = 2'd0;
    int         width = 0;

    keypad_symbol_tx #(
        .DEBOUNCE_CYCLES(DEB),
        .SETUP_CYCLES   (SET),
        .STROBE_CYCLES  (STB)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN    (BTN),
        .KB_RECV(KB_RECV),
        .KB_IN  (KB_IN),
        .BUSY   (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] sym);
        sb_q.push_back(sym);
        n_push++;
    endtask

    task automatic press(input logic [1:0] sym, input int hold, input int gap);
        push(sym);
        BTN = 4'b0001 << sym;
        repeat (hold) @(posedge CLK);
        #1 BTN = 4'd0;
        repeat (gap) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_recv = 1'b0;
            width     = 0;
        end else begin
            if (KB_RECV && !prev_recv) begin
                n_strobe++;
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    cur_exp = sb_q.pop_front();
                    chk("kb_in_rise", KB_IN, cur_exp);
                    chk("kb_in_setup", prev_kb, cur_exp);
                end
                width = 1;
            end else if (KB_RECV) begin
                width++;
                chk("kb_in_hold", KB_IN, cur_exp);
            end else if (prev_recv) begin
                chk("strobe_w", width, STB);
                chk("kb_in_fall", KB_IN, cur_exp);
            end
            prev_recv = KB_RECV;
            prev_kb   = KB_IN;
        end
    end

    initial begin
        int base;
        logic [1:0] seq [4];
        seq[0] = 2'd0; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd2;
        RST_N = 1'b0;
        BTN   = 4'd0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_recv", KB_RECV, 0);
        chk("rst_kb_in", KB_IN, 0);
        chk("rst_busy", BUSY, 0);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Timed single press: edge n=0 is the first edge with BTN stable before it
        push(2'd2);
        BTN = 4'b0100;
        for (int n = 0; n <= 30; n++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("t_recv_%0d", n), KB_RECV, (n >= 20 && n <= 23));
            chk($sformatf("t_busy_%0d", n), BUSY, (n >= 2));
            chk($sformatf("t_kb_in_%0d", n), KB_IN, (n >= 18) ? 2 : 0);
        end
        BTN = 4'd0;
        repeat (30) @(posedge CLK);
        #1;
        chk("busy_after_release", BUSY, 0);

        // Asynchronous reset mid-cycle
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_recv", KB_RECV, 0);
        chk("arst_kb_in", KB_IN, 0);
        chk("arst_busy", BUSY, 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;

        // Reset during STROBE truncates the strobe; held key then counts as new press
        push(2'd1);
        BTN = 4'b0010;
        for (int i = 0; i < 60 && !KB_RECV; i++) begin
            @(posedge CLK);
            #1;
        end
        chk("strobe_seen", KB_RECV, 1);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("strobe_cut_recv", KB_RECV, 0);
        chk("strobe_cut_busy", BUSY, 0);
        repeat (2) @(posedge CLK);
        push(2'd1);
        #1 RST_N = 1'b1;
        repeat (40) @(posedge CLK);
        #1 BTN = 4'd0;
        repeat (40) @(posedge CLK);
        #1;
        chk("re_press_count", n_strobe, 3);

        // Bounce rejection
        base = n_strobe;
        for (int i = 0; i < 12; i++) begin
            BTN = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (5) @(posedge CLK);
            #1;
        end
        BTN = 4'd0;
        repeat (30) @(posedge CLK);
        #1;
        chk("bounce_strobes", n_strobe, base);
        chk("bounce_busy", BUSY, 0);
        chk("bounce_kb_in", KB_IN, 1);

        // Multi-key rejection, then single key accepted
        BTN = 4'b0011;
        repeat (100) @(posedge CLK);
        #1;
        chk("multi_strobes", n_strobe, base);
        chk("multi_busy", BUSY, 0);
        press(2'd0, 40, 40);
        chk("multi_then_single", n_strobe, base + 1);

        // Held key gives exactly one strobe; re-press after release gives another
        base = n_strobe;
        push(2'd3);
        BTN = 4'b1000;
        repeat (500) @(posedge CLK);
        #1;
        chk("held_strobes", n_strobe, base + 1);
        chk("held_busy", BUSY, 1);
        BTN = 4'd0;
        repeat (40) @(posedge CLK);
        #1;
        press(2'd3, 40, 40);
        chk("held_repress", n_strobe, base + 2);
        chk("held_kb_in", KB_IN, 3);

        // Code sequence 0,3,1,2
        for (int i = 0; i < 4; i++) begin
            press(seq[i], 40, 40);
            chk($sformatf("seq_kb_in_%0d", i), KB_IN, seq[i]);
        end

        chk("sb_drained", sb_q.size(), 0);
        chk("strobe_total", n_strobe, n_push);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
